// File: rtl/fp_mult_rr_arbiter.sv
// Round-robin front end sharing one fixed-latency FP multiplier between two requesters.
// Optional per-requester grant counters are enabled with `define FP_MULT_ARB_STATS_EN.
module fp_mult_rr_arbiter #(
    parameter int SIG_WIDTH = 23,
    parameter int EXP_WIDTH = 8,
    parameter int MULT_LAT  = 3,
    localparam int W        = 1 + EXP_WIDTH + SIG_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
`ifdef FP_MULT_ARB_STATS_EN
    input  logic         stats_clr,
    output logic [15:0]  grant0_cnt,
    output logic [15:0]  grant1_cnt,
`endif
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         mul_in_valid,
    output logic [W-1:0] mul_a,
    output logic [W-1:0] mul_b,
    input  logic [W-1:0] mul_result,
    output logic         resp0_valid,
    output logic         resp1_valid,
    output logic [W-1:0] resp_data,
    output logic         busy
);

    logic grant0;
    logic grant1;

    logic         last_grant_q,   last_grant_d;
    logic         mul_in_valid_q, mul_in_valid_d;
    logic         issue_owner_q,  issue_owner_d;
    logic [W-1:0] mul_a_q,        mul_a_d;
    logic [W-1:0] mul_b_q,        mul_b_d;

    logic [MULT_LAT-1:0] tag_valid_q, tag_valid_d;
    logic [MULT_LAT-1:0] tag_owner_q, tag_owner_d;

    logic         resp0_valid_q, resp0_valid_d;
    logic         resp1_valid_q, resp1_valid_d;
    logic [W-1:0] resp_data_q,   resp_data_d;

    // On contention the requester that did not win last time gets the slot.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (req0_valid && (!req1_valid || last_grant_q)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    always_comb begin
        mul_in_valid_d = grant0 | grant1;
        last_grant_d   = last_grant_q;
        issue_owner_d  = issue_owner_q;
        mul_a_d        = mul_a_q;
        mul_b_d        = mul_b_q;
        if (grant0) begin
            last_grant_d  = 1'b0;
            issue_owner_d = 1'b0;
            mul_a_d       = req0_a;
            mul_b_d       = req0_b;
        end else if (grant1) begin
            last_grant_d  = 1'b1;
            issue_owner_d = 1'b1;
            mul_a_d       = req1_a;
            mul_b_d       = req1_b;
        end
    end

    // Stage 0 captures the op on the multiplier inputs, so the tail lines up with mul_result.
    always_comb begin
        tag_valid_d    = '0;
        tag_owner_d    = '0;
        tag_valid_d[0] = mul_in_valid_q;
        tag_owner_d[0] = issue_owner_q;
        for (int i = 1; i < MULT_LAT; i++) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_owner_d[i] = tag_owner_q[i-1];
        end
    end

    always_comb begin
        resp0_valid_d = tag_valid_q[MULT_LAT-1] & ~tag_owner_q[MULT_LAT-1];
        resp1_valid_d = tag_valid_q[MULT_LAT-1] &  tag_owner_q[MULT_LAT-1];
        resp_data_d   = tag_valid_q[MULT_LAT-1] ? mul_result : resp_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q   <= 1'b1;
            mul_in_valid_q <= 1'b0;
            issue_owner_q  <= 1'b0;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
            tag_valid_q    <= '0;
            tag_owner_q    <= '0;
            resp0_valid_q  <= 1'b0;
            resp1_valid_q  <= 1'b0;
            resp_data_q    <= '0;
        end else begin
            last_grant_q   <= last_grant_d;
            mul_in_valid_q <= mul_in_valid_d;
            issue_owner_q  <= issue_owner_d;
            mul_a_q        <= mul_a_d;
            mul_b_q        <= mul_b_d;
            tag_valid_q    <= tag_valid_d;
            tag_owner_q    <= tag_owner_d;
            resp0_valid_q  <= resp0_valid_d;
            resp1_valid_q  <= resp1_valid_d;
            resp_data_q    <= resp_data_d;
        end
    end

`ifdef FP_MULT_ARB_STATS_EN
    logic [15:0] grant0_cnt_q, grant0_cnt_d;
    logic [15:0] grant1_cnt_q, grant1_cnt_d;

    // Clear wins over a same-cycle increment; counts saturate rather than wrap.
    always_comb begin
        grant0_cnt_d = grant0_cnt_q;
        grant1_cnt_d = grant1_cnt_q;
        if (stats_clr) begin
            grant0_cnt_d = '0;
            grant1_cnt_d = '0;
        end else begin
            if (grant0 && grant0_cnt_q != 16'hFFFF) grant0_cnt_d = grant0_cnt_q + 16'd1;
            if (grant1 && grant1_cnt_q != 16'hFFFF) grant1_cnt_d = grant1_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant0_cnt_q <= '0;
            grant1_cnt_q <= '0;
        end else begin
            grant0_cnt_q <= grant0_cnt_d;
            grant1_cnt_q <= grant1_cnt_d;
        end
    end

    assign grant0_cnt = grant0_cnt_q;
    assign grant1_cnt = grant1_cnt_q;
`endif

    assign req0_ready   = grant0;
    assign req1_ready   = grant1;
    assign mul_in_valid = mul_in_valid_q;
    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;
    assign resp0_valid  = resp0_valid_q;
    assign resp1_valid  = resp1_valid_q;
    assign resp_data    = resp_data_q;
    assign busy         = mul_in_valid_q | (|tag_valid_q) | resp0_valid_q | resp1_valid_q;

endmodule

// File: tb/tb_fp_mult_rr_arbiter.sv
// Scoreboard bench for fp_mult_rr_arbiter with a delay-line multiplier model.
// Stats counters are exercised when FP_MULT_ARB_STATS_EN is defined.
module tb_fp_mult_rr_arbiter;

    localparam int LAT = 3;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    typedef struct {
        logic        owner;
        logic [31:0] data;
        int          cyc;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        mul_in_valid;
    logic [31:0] mul_a, mul_b, mul_result;
    logic        resp0_valid, resp1_valid, busy;
    logic [31:0] resp_data;
`ifdef FP_MULT_ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] grant0_cnt, grant1_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    op_t  pend0[$];
    op_t  pend1[$];
    sb_t  sb[$];
    logic log_owner[$];
    int   log_cyc[$];

    logic        model_last;
    logic        exp_mv;
    logic [31:0] exp_ma, exp_mb;
    logic [31:0] dl [LAT];

    fp_mult_rr_arbiter #(.SIG_WIDTH(23), .EXP_WIDTH(8), .MULT_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
`ifdef FP_MULT_ARB_STATS_EN
        .stats_clr(stats_clr), .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt),
`endif
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .mul_in_valid(mul_in_valid), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_data(resp_data), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3FC00000_40000000: return 32'h40400000;
            64'h3F800000_3F800000: return 32'h3F800000;
            64'h40000000_40400000: return 32'h40C00000;
            64'hBF800000_40800000: return 32'hC0800000;
            64'h3F000000_3F000000: return 32'h3E800000;
            default:               return a ^ {b[15:0], b[31:16]};
        endcase
    endfunction

    // Multiplier model: result appears LAT cycles after the issue strobe, junk otherwise.
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) dl[i] <= dl[i-1];
        dl[0] <= mul_in_valid ? fmul(mul_a, mul_b) : 32'h7FC0DEAD;
    end
    assign mul_result = dl[LAT-1];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [31:0] a, input logic [31:0] b);
        op_t op;
        op.a = a;
        op.b = b;
        if (req) pend1.push_back(op);
        else     pend0.push_back(op);
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while ((pend0.size() != 0 || pend1.size() != 0 || sb.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        checkOutput(tag, 32'(pend0.size() + pend1.size() + sb.size()), 32'd0);
        repeat (2) @(posedge clk);
    endtask

    // Requesters present the head of their pending queue and hold it until accepted.
    always @(posedge clk) begin
        #1;
        req0_valid = (pend0.size() != 0);
        req1_valid = (pend1.size() != 0);
        if (req0_valid) begin req0_a = pend0[0].a; req0_b = pend0[0].b; end
        if (req1_valid) begin req1_a = pend1[0].a; req1_b = pend1[0].b; end
    end

    // Mid-cycle monitor: grant model, issue model, busy, and scoreboard response checks.
    always @(negedge clk) begin
        logic exp_g0, exp_g1;
        sb_t  e;
        if (rst) begin
            sb.delete();
            model_last = 1'b1;
            exp_mv     = 1'b0;
            exp_ma     = 32'd0;
            exp_mb     = 32'd0;
            checkOutput("rst_ready0",    32'(req0_ready),   32'd0);
            checkOutput("rst_ready1",    32'(req1_ready),   32'd0);
            checkOutput("rst_mul_valid", 32'(mul_in_valid), 32'd0);
            checkOutput("rst_resp0",     32'(resp0_valid),  32'd0);
            checkOutput("rst_resp1",     32'(resp1_valid),  32'd0);
            checkOutput("rst_resp_data", resp_data,         32'd0);
            checkOutput("rst_busy",      32'(busy),         32'd0);
        end else begin
            exp_g0 = req0_valid && (!req1_valid || model_last);
            exp_g1 = req1_valid && !exp_g0;
            checkOutput("ready0",      32'(req0_ready),   32'(exp_g0));
            checkOutput("ready1",      32'(req1_ready),   32'(exp_g1));
            checkOutput("busy",        32'(busy),         32'(sb.size() != 0));
            checkOutput("mul_valid",   32'(mul_in_valid), 32'(exp_mv));
            checkOutput("mul_a",       mul_a,             exp_ma);
            checkOutput("mul_b",       mul_b,             exp_mb);
            checkOutput("resp_onehot", 32'(resp0_valid & resp1_valid), 32'd0);
            if (resp0_valid || resp1_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("resp_unexpected", 32'(resp0_valid | resp1_valid), 32'(sb.size() != 0));
                end else begin
                    e = sb.pop_front();
                    checkOutput("resp_owner",   32'(resp1_valid), 32'(e.owner));
                    checkOutput("resp_data",    resp_data,        e.data);
                    checkOutput("resp_latency", 32'(cyc - e.cyc), 32'(2 + LAT));
                end
            end
            exp_mv = 1'b0;
            if (exp_g0 || exp_g1) begin
                e.owner    = exp_g1;
                e.cyc      = cyc;
                exp_mv     = 1'b1;
                exp_ma     = exp_g1 ? req1_a : req0_a;
                exp_mb     = exp_g1 ? req1_b : req0_b;
                e.data     = fmul(exp_ma, exp_mb);
                model_last = exp_g1;
                sb.push_back(e);
                log_owner.push_back(exp_g1);
                log_cyc.push_back(cyc);
                if (exp_g1) void'(pend1.pop_front());
                else        void'(pend0.pop_front());
            end
        end
    end

    initial begin
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
`ifdef FP_MULT_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Single operation on requester 0.
        log_owner.delete(); log_cyc.delete();
        applyStimulus(1'b0, 32'h3FC00000, 32'h40000000);
        waitDrain("single_drain");
        checkOutput("single_count", 32'(log_owner.size()), 32'd1);

        // Contention straight out of reset.
        @(posedge clk); #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h41000000 + 32'(i), 32'h42000000 + 32'(i));
            applyStimulus(1'b1, 32'h43000000 + 32'(i), 32'h44000000 + 32'(i));
        end
        log_owner.delete(); log_cyc.delete();
        @(posedge clk); #2 rst = 1'b0;
        waitDrain("contend_drain");
        checkOutput("contend_count", 32'(log_owner.size()), 32'd6);
        for (int i = 0; i < log_owner.size(); i++) begin
            checkOutput("contend_order", 32'(log_owner[i]), 32'(i % 2));
            checkOutput("contend_spacing", 32'(log_cyc[i] - log_cyc[0]), 32'(i));
        end

        // Single continuous streamer on requester 1.
        log_owner.delete(); log_cyc.delete();
        applyStimulus(1'b1, 32'h3F800000, 32'h3F800000);
        applyStimulus(1'b1, 32'h40000000, 32'h40400000);
        applyStimulus(1'b1, 32'hBF800000, 32'h40800000);
        applyStimulus(1'b1, 32'h3F000000, 32'h3F000000);
        waitDrain("stream_drain");
        checkOutput("stream_count", 32'(log_owner.size()), 32'd4);
        for (int i = 0; i < log_owner.size(); i++) begin
            checkOutput("stream_owner", 32'(log_owner[i]), 32'd1);
            checkOutput("stream_spacing", 32'(log_cyc[i] - log_cyc[0]), 32'(i));
        end

        // Idle gap between two isolated ops; monitor checks busy and operand hold.
        applyStimulus(1'b0, 32'h12345678, 32'h9ABCDEF0);
        waitDrain("gap_drain_a");
        repeat (3) @(posedge clk);
        applyStimulus(1'b1, 32'h0F0F0F0F, 32'hF0F0F0F0);
        waitDrain("gap_drain_b");

        // Reset while three ops are in flight.
        log_owner.delete(); log_cyc.delete();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h3C000000 + 32'(i), 32'h3D000000);
        begin
            int n = 0;
            while (log_owner.size() < 3 && n < 50) begin
                @(posedge clk);
                n++;
            end
        end
        checkOutput("midrst_accepts", 32'(log_owner.size()), 32'd3);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_mul_valid", 32'(mul_in_valid), 32'd0);
        checkOutput("midrst_busy",      32'(busy),         32'd0);
        checkOutput("midrst_resp_data", resp_data,         32'd0);
        @(posedge clk); #2 rst = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        log_owner.delete(); log_cyc.delete();
        applyStimulus(1'b1, 32'h11111111, 32'h22222222);
        applyStimulus(1'b0, 32'h33333333, 32'h44444444);
        waitDrain("postrst_drain");
        checkOutput("postrst_count", 32'(log_owner.size()), 32'd2);
        if (log_owner.size() != 0) checkOutput("postrst_first", 32'(log_owner[0]), 32'd0);

`ifdef FP_MULT_ARB_STATS_EN
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        checkOutput("cnt0_reset", 32'(grant0_cnt), 32'd0);
        checkOutput("cnt1_reset", 32'(grant1_cnt), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h50000000 + 32'(i), 32'h51000000);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 32'h52000000 + 32'(i), 32'h53000000);
        waitDrain("stats_drain");
        @(negedge clk);
        checkOutput("cnt0", 32'(grant0_cnt), 32'd3);
        checkOutput("cnt1", 32'(grant1_cnt), 32'd2);
        @(posedge clk);
        applyStimulus(1'b0, 32'h54000000, 32'h55000000);
        #1 stats_clr = 1'b1;
        @(posedge clk); #1 stats_clr = 1'b0;
        @(negedge clk);
        checkOutput("cnt0_clr", 32'(grant0_cnt), 32'd0);
        checkOutput("cnt1_clr", 32'(grant1_cnt), 32'd0);
        waitDrain("stats_clr_drain");
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
